// File: rtl/xprog_loader_if.sv
// Byte stream in, program-memory write port out.
// Host side drives bytes; loader side answers and writes words.
interface xprog_loader_if #(
  parameter int INSTR_W     = 32,
  parameter int PROG_ADDR_W = 10
) ();
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   prog_we;
  logic [PROG_ADDR_W-1:0] prog_addr;
  logic [INSTR_W-1:0]     prog_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, prog_we, prog_addr, prog_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, prog_we, prog_addr, prog_wdata
  );
endinterface

// File: rtl/xprog_loader.sv
// Boot loader: framed byte stream -> program RAM words with XOR check.
// Holds the controller in reset until a frame loads cleanly.
module xprog_loader #(
  parameter int INSTR_W     = 32,
  parameter int PROG_ADDR_W = 10,
  parameter int LOAD_BASE   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  xprog_loader_if.slave bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);
  localparam int BPW = INSTR_W / 8;
  localparam int DEPTH = 1 << PROG_ADDR_W;
  localparam logic [16:0] MAX_N = 17'(DEPTH - LOAD_BASE);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic [7:0]         len_hi;
  logic [15:0]        n;
  logic [15:0]        idx;
  logic [7:0]         byte_cnt;
  logic [INSTR_W-1:0] word;
  logic [7:0]         csum;

  logic               acc;
  logic [16:0]        n_rx;
  logic               last_byte;
  logic               last_word;
  logic [INSTR_W-1:0] word_nx;

  assign acc       = bus.in_valid & bus.in_ready;
  assign n_rx      = {1'b0, len_hi, bus.in_data};
  assign last_byte = byte_cnt == 8'(BPW - 1);
  assign last_word = idx == n - 16'd1;
  assign word_nx   = (word << 8) | INSTR_W'(bus.in_data);

  assign bus.in_ready = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
  assign cpu_rst      = state != S_DONE;
  assign done         = state == S_DONE;
  assign err          = state == S_ERR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN_HI;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_LEN_HI: if (acc) state_nx = S_LEN_LO;
      S_LEN_LO:
        if (acc) begin
          if (n_rx > MAX_N)       state_nx = S_ERR;
          else if (n_rx == 17'd0) state_nx = S_CSUM;
          else                    state_nx = S_DATA;
        end
      S_DATA:
        if (acc && last_byte && last_word) state_nx = S_CSUM;
      S_CSUM:
        if (acc) state_nx = (bus.in_data == csum) ? S_DONE : S_ERR;
      S_DONE:   if (reload) state_nx = S_LEN_HI;
      S_ERR:    if (reload) state_nx = S_LEN_HI;
      default:  state_nx = S_LEN_HI;
    endcase
  end

  // prog_* are registered so word k is written while word k+1 streams in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_hi         <= '0;
      n              <= '0;
      idx            <= '0;
      byte_cnt       <= '0;
      word           <= '0;
      csum           <= '0;
      bus.prog_we    <= 1'b0;
      bus.prog_addr  <= PROG_ADDR_W'(LOAD_BASE);
      bus.prog_wdata <= '0;
    end else begin
      bus.prog_we <= 1'b0;
      if (acc) begin
        unique case (state)
          S_LEN_HI: begin
            len_hi <= bus.in_data;
            csum   <= bus.in_data;
          end
          S_LEN_LO: begin
            n        <= n_rx[15:0];
            csum     <= csum ^ bus.in_data;
            idx      <= '0;
            byte_cnt <= '0;
            word     <= '0;
          end
          S_DATA: begin
            csum <= csum ^ bus.in_data;
            if (last_byte) begin
              byte_cnt       <= '0;
              word           <= '0;
              bus.prog_we    <= 1'b1;
              bus.prog_addr  <= PROG_ADDR_W'(LOAD_BASE)
                              + idx[PROG_ADDR_W-1:0];
              bus.prog_wdata <= word_nx;
              idx            <= idx + 16'd1;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              word     <= word_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xprog_loader.sv
// Directed bench for xprog_loader: framing, checksum, length
// limits, stalls, reload and mid-word reset.
module tb_xprog_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic cpu_rst, done, err;

  xprog_loader_if #(.INSTR_W(32), .PROG_ADDR_W(10)) bus ();

  xprog_loader #(
    .INSTR_W(32), .PROG_ADDR_W(10), .LOAD_BASE(0)
  ) dut (
    .clk(clk), .rst(rst), .reload(reload),
    .bus(bus.slave),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_drops = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge clk)
    if (rst && bus.prog_we) begin
      wa.push_back(bus.prog_addr);
      wd.push_back(bus.prog_wdata);
    end

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    if (!bus.in_ready) rdy_drops++;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rdy_drops = 0;
  endtask

  task automatic send_frame(input logic [31:0] w[$],
                            input logic [7:0] cs_flip,
                            input bit gaps);
    logic [15:0] nw;
    logic [7:0] cs;
    logic [7:0] b;
    nw = 16'(w.size());
    cs = nw[15:8] ^ nw[7:0];
    send(nw[15:8], 0);
    send(nw[7:0], 0);
    foreach (w[i])
      for (int k = 3; k >= 0; k--) begin
        b = w[i][8*k +: 8];
        cs ^= b;
        send(b, gaps ? int'($urandom_range(0, 2)) : 0);
      end
    send(cs ^ cs_flip, 0);
    idle();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.in_ready, bus.prog_we, cpu_rst, done, err} !== 5'b10100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 10100",
               {bus.in_ready, bus.prog_we, cpu_rst, done, err});
    end
    n_chk++;
    if (bus.prog_addr !== 10'd0 || bus.prog_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_prog: got %h/%h expected 000/00000000",
               bus.prog_addr, bus.prog_wdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_word();
    clear_log();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'h56, 0);
    send(8'h78, 0);
    #1;
    n_chk++;
    if ({bus.prog_we, bus.prog_addr, bus.prog_wdata} !== {1'b1, 10'd0, 32'h12345678}) begin
      n_fail++;
      $display("FAIL single_latency: got we=%b a=%h d=%h expected 1/000/12345678",
               bus.prog_we, bus.prog_addr, bus.prog_wdata);
    end
    send(8'h09, 0);
    idle();
    n_chk++;
    if ({done, err, cpu_rst, bus.in_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_done: got %b expected 1000",
               {done, err, cpu_rst, bus.in_ready});
    end
    n_chk++;
    if (wa.size() !== 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d expected 1", wa.size());
    end
  endtask

  task automatic test_back_to_back(input bit gaps, input string tag);
    logic [31:0] w[$];
    w = '{32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A};
    do_reload();
    n_chk++;
    if ({cpu_rst, done, err} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s_reload: got %b expected 100", tag, {cpu_rst, done, err});
    end
    clear_log();
    send_frame(w, 8'h00, gaps);
    n_chk++;
    if (wa.size() !== 3) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected 3", tag, wa.size());
    end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_chk++;
      if (wa[i] !== 10'(i) || wd[i] !== w[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d: got %h/%h expected %h/%h",
                 tag, i, wa[i], wd[i], 10'(i), w[i]);
      end
    end
    n_chk++;
    if (rdy_drops !== 0 || done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: got drops=%0d done=%b cpu_rst=%b expected 0/1/0",
               tag, rdy_drops, done, cpu_rst);
    end
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[$];
    w = '{32'h12345678};
    do_reload();
    clear_log();
    send_frame(w, 8'h03, 1'b0);
    n_chk++;
    if ({err, done, cpu_rst, bus.in_ready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL badcs_err: got %b expected 1010",
               {err, done, cpu_rst, bus.in_ready});
    end
    n_chk++;
    if (wa.size() !== 1 || wd[0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL badcs_write: got n=%0d expected 1 word 12345678", wa.size());
    end
    do_reload();
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL badcs_clear: got err=%b expected 0", err);
    end
    send_frame(w, 8'h00, 1'b0);
    n_chk++;
    if ({done, err, cpu_rst} !== 3'b100) begin
      n_fail++;
      $display("FAIL badcs_retry: got %b expected 100", {done, err, cpu_rst});
    end
  endtask

  task automatic test_length();
    do_reload();
    clear_log();
    send(8'h04, 0);
    send(8'h01, 0);
    idle();
    n_chk++;
    if ({err, bus.in_ready, cpu_rst} !== 3'b101) begin
      n_fail++;
      $display("FAIL len_over: got %b expected 101", {err, bus.in_ready, cpu_rst});
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (wa.size() !== 0) begin
      n_fail++;
      $display("FAIL len_over_writes: got %0d expected 0", wa.size());
    end
    do_reload();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    idle();
    n_chk++;
    if ({done, err, wa.size() == 0} !== 3'b101) begin
      n_fail++;
      $display("FAIL len_zero: got done=%b err=%b writes=%0d expected 1/0/0",
               done, err, wa.size());
    end
  endtask

  task automatic test_midword_reset();
    logic [31:0] w[$];
    w = '{32'hCAFEF00D};
    do_reload();
    clear_log();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hAB, 0);
    send(8'hCD, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.prog_we, cpu_rst, done, err} !== 5'b10100
        || bus.prog_addr !== 10'd0 || bus.prog_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_state: got %b a=%h d=%h expected 10100/000/00000000",
               {bus.in_ready, bus.prog_we, cpu_rst, done, err},
               bus.prog_addr, bus.prog_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    send_frame(w, 8'h00, 1'b0);
    n_chk++;
    if (wa.size() !== 1 || wa[0] !== 10'd0 || wd[0] !== 32'hCAFEF00D || done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_reload: got n=%0d done=%b expected 1 word CAFEF00D at 000, done 1",
               wa.size(), done);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back(1'b0, "b2b");
    test_bad_csum();
    test_length();
    test_back_to_back(1'b1, "gaps");
    test_midword_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
